m_memarb: RTL and testbench

- Two-requester arbiter and sequencer for one shared single-port 4K x 32 data memory (an m_amemory instance).
- Port 0 is the processor load/store path. Port 1 is a loader/debug path that fills or inspects memory.
- The block grants one requester at a time, drives the memory, times the access and returns a completion pulse with read data.

---
 rtl/m_memarb_pkg.sv | 18 +
 rtl/m_memarb_if.sv | 38 +++
 rtl/m_memarb_pick.sv | 29 ++
 rtl/m_memarb.sv | 127 ++++++++++++
 tb/tb_m_memarb.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/m_memarb_pkg.sv
// Shared definitions for the two-port memory arbiter: FSM state encoding,
// requester port ids and the access-latency counter width.
package memarb_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACC  = 2'd1,
        S_RESP = 2'd2
    } state_t;

    // Requester port ids (index into the 2-bit req/gnt/done vectors)
    localparam logic P_CPU = 1'b0;
    localparam logic P_LDR = 1'b1;

    // Width of the latency down-counter; holds LAT-1 for LAT up to 15
    localparam int CW = 4;

endpackage

// File: rtl/m_memarb_if.sv
// Bus bundle between the requesters, the arbiter and the shared memory.
// slave  : arbiter side
// master : requester side (CPU port 0, loader port 1)
// mem    : memory side (address/strobe in, read data out)
interface m_memarb_if #(
    parameter int AW = 12,
    parameter int DW = 32
);
    logic [1:0]    w_req;
    logic [1:0]    w_we;
    logic [AW-1:0] w_addr0;
    logic [AW-1:0] w_addr1;
    logic [DW-1:0] w_wdata0;
    logic [DW-1:0] w_wdata1;
    logic [1:0]    r_gnt;
    logic [1:0]    r_done;
    logic [DW-1:0] r_rdata;
    logic          r_busy;
    logic [AW-1:0] r_mem_addr;
    logic          r_mem_we;
    logic [DW-1:0] r_mem_din;
    logic [DW-1:0] w_mem_dout;

    modport slave (
        input  w_req, w_we, w_addr0, w_addr1, w_wdata0, w_wdata1, w_mem_dout,
        output r_gnt, r_done, r_rdata, r_busy, r_mem_addr, r_mem_we, r_mem_din
    );

    modport master (
        output w_req, w_we, w_addr0, w_addr1, w_wdata0, w_wdata1,
        input  r_gnt, r_done, r_rdata, r_busy
    );

    modport mem (
        input  r_mem_addr, r_mem_we, r_mem_din,
        output w_mem_dout
    );
endinterface

// File: rtl/m_memarb_pick.sv
// Combinational winner selection for the two requesters.
// Build option: MEMARB_FIXPRIO_EN -- when defined, port 0 always wins a tie;
// otherwise ties go to the port that was not served last (round robin).
module m_memarb_pick
    import memarb_pkg::*;
(
    input  logic [1:0] w_req,
    input  logic       r_last,
    output logic       w_winner,
    output logic       w_valid
);

    // Choose the port to grant from the current request vector
    always_comb begin
        w_valid  = |w_req;
        w_winner = P_CPU;
        case (w_req)
            2'b01:   w_winner = P_CPU;
            2'b10:   w_winner = P_LDR;
`ifdef MEMARB_FIXPRIO_EN
            2'b11:   w_winner = P_CPU;
`else
            2'b11:   w_winner = ~r_last;
`endif
            default: w_winner = P_CPU;
        endcase
    end

endmodule

// File: rtl/m_memarb.sv
// Two-requester arbiter/sequencer for one shared single-port memory.
// Grants one port at a time, strobes the memory, waits LAT cycles for read
// data and returns a one-cycle done pulse. All outputs are registered.
// Build option: MEMARB_FIXPRIO_EN (fixed priority, handled in m_memarb_pick).
module m_memarb
    import memarb_pkg::*;
#(
    parameter int LAT = 1,
    parameter int AW  = 12,
    parameter int DW  = 32
)
(
    input  logic      w_clk,
    input  logic      w_rst_n,
    m_memarb_if.slave bus
);

    generate
        if (LAT < 1 || LAT > 15) begin : g_lat_check
            $error("m_memarb: LAT must be in 1..15");
        end
    endgenerate

    state_t        r_state,  w_state_next;
    logic [CW-1:0] r_cnt,    w_cnt_next;
    logic          r_winner, w_winner_next;
    logic          r_last,   w_last_next;
    logic          r_is_wr,  w_is_wr_next;
    logic [1:0]    w_gnt_next;
    logic [1:0]    w_done_next;
    logic          w_busy_next;
    logic [DW-1:0] w_rdata_next;
    logic [AW-1:0] w_addr_next;
    logic          w_we_next;
    logic [DW-1:0] w_din_next;
    logic          w_pick_id;
    logic          w_pick_valid;

    m_memarb_pick u_pick (
        .w_req    (bus.w_req),
        .r_last   (r_last),
        .w_winner (w_pick_id),
        .w_valid  (w_pick_valid)
    );

    // Next-state and next-output logic; strobes default low so they pulse once
    always_comb begin
        w_state_next  = r_state;
        w_cnt_next    = r_cnt;
        w_winner_next = r_winner;
        w_last_next   = r_last;
        w_is_wr_next  = r_is_wr;
        w_gnt_next    = 2'b00;
        w_done_next   = 2'b00;
        w_busy_next   = bus.r_busy;
        w_rdata_next  = bus.r_rdata;
        w_addr_next   = bus.r_mem_addr;
        w_we_next     = 1'b0;
        w_din_next    = bus.r_mem_din;
        case (r_state)
            S_IDLE: begin
                if (w_pick_valid) begin
                    w_winner_next = w_pick_id;
                    w_is_wr_next  = bus.w_we[w_pick_id];
                    w_we_next     = bus.w_we[w_pick_id];
                    w_addr_next   = (w_pick_id == P_LDR) ? bus.w_addr1  : bus.w_addr0;
                    w_din_next    = (w_pick_id == P_LDR) ? bus.w_wdata1 : bus.w_wdata0;
                    w_gnt_next    = 2'b01 << w_pick_id;
                    w_busy_next   = 1'b1;
                    w_cnt_next    = CW'(LAT - 1);
                    w_state_next  = S_ACC;
                end
            end
            S_ACC: begin
                if (r_cnt == '0) begin
                    if (!r_is_wr) begin
                        w_rdata_next = bus.w_mem_dout;
                    end
                    w_state_next = S_RESP;
                end else begin
                    w_cnt_next = r_cnt - 1'b1;
                end
            end
            S_RESP: begin
                w_done_next  = 2'b01 << r_winner;
                w_busy_next  = 1'b0;
                w_last_next  = r_winner;
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // State and output registers; reset abandons any in-flight access
    always_ff @(posedge w_clk) begin
        if (!w_rst_n) begin
            r_state        <= S_IDLE;
            r_cnt          <= '0;
            r_winner       <= P_CPU;
            r_last         <= 1'b1;
            r_is_wr        <= 1'b0;
            bus.r_gnt      <= 2'b00;
            bus.r_done     <= 2'b00;
            bus.r_busy     <= 1'b0;
            bus.r_rdata    <= '0;
            bus.r_mem_addr <= '0;
            bus.r_mem_we   <= 1'b0;
            bus.r_mem_din  <= '0;
        end else begin
            r_state        <= w_state_next;
            r_cnt          <= w_cnt_next;
            r_winner       <= w_winner_next;
            r_last         <= w_last_next;
            r_is_wr        <= w_is_wr_next;
            bus.r_gnt      <= w_gnt_next;
            bus.r_done     <= w_done_next;
            bus.r_busy     <= w_busy_next;
            bus.r_rdata    <= w_rdata_next;
            bus.r_mem_addr <= w_addr_next;
            bus.r_mem_we   <= w_we_next;
            bus.r_mem_din  <= w_din_next;
        end
    end

endmodule

// File: tb/tb_m_memarb.sv
// Directed testbench for m_memarb: one LAT=1 instance and one LAT=3 instance,
// each backed by a simple behavioural memory with the matching read latency.
module tb_m_memarb;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;

    m_memarb_if #(.AW(12), .DW(32)) if1 ();
    m_memarb_if #(.AW(12), .DW(32)) if3 ();

    m_memarb #(.LAT(1), .AW(12), .DW(32)) u_dut1 (.w_clk(clk), .w_rst_n(rst_n), .bus(if1));
    m_memarb #(.LAT(3), .AW(12), .DW(32)) u_dut3 (.w_clk(clk), .w_rst_n(rst_n), .bus(if3));

    // Memory models: LAT=1 reads the current address, LAT=3 reads an address
    // delayed by two clocks so a short counter would capture stale data.
    logic [31:0] mem1 [0:4095];
    logic [31:0] mem3 [0:4095];
    logic [11:0] a3_d1 = '0;
    logic [11:0] a3_d2 = '0;

    always @(posedge clk) begin
        if (if1.r_mem_we) mem1[if1.r_mem_addr] <= if1.r_mem_din;
        if (if3.r_mem_we) mem3[if3.r_mem_addr] <= if3.r_mem_din;
        a3_d1 <= if3.r_mem_addr;
        a3_d2 <= a3_d1;
    end

    assign if1.w_mem_dout = mem1[if1.r_mem_addr];
    assign if3.w_mem_dout = mem3[a3_d2];

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        if1.w_req = 2'b00; if1.w_we = 2'b00;
        if1.w_addr0 = '0; if1.w_addr1 = '0; if1.w_wdata0 = '0; if1.w_wdata1 = '0;
        if3.w_req = 2'b00; if3.w_we = 2'b00;
        if3.w_addr0 = '0; if3.w_addr1 = '0; if3.w_wdata0 = '0; if3.w_wdata1 = '0;
    endtask

    task automatic test_reset;
        idle_inputs();
        rst_n = 1'b0;
        tick(); tick();
        n_total++; if (if1.r_gnt !== 2'b00) begin n_bad++; $display("FAIL reset_gnt1: got %b want 00", if1.r_gnt); end
        n_total++; if (if1.r_done !== 2'b00) begin n_bad++; $display("FAIL reset_done1: got %b want 00", if1.r_done); end
        n_total++; if (if1.r_busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy1: got %b want 0", if1.r_busy); end
        n_total++; if (if1.r_rdata !== 32'h0) begin n_bad++; $display("FAIL reset_rdata1: got %h want 0", if1.r_rdata); end
        n_total++; if (if1.r_mem_we !== 1'b0) begin n_bad++; $display("FAIL reset_we1: got %b want 0", if1.r_mem_we); end
        n_total++; if (if1.r_mem_addr !== 12'h0) begin n_bad++; $display("FAIL reset_addr1: got %h want 0", if1.r_mem_addr); end
        n_total++; if (if1.r_mem_din !== 32'h0) begin n_bad++; $display("FAIL reset_din1: got %h want 0", if1.r_mem_din); end
        n_total++; if (if3.r_busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy3: got %b want 0", if3.r_busy); end
        rst_n = 1'b1;
        $display("txn reset: outputs checked");
    endtask

    task automatic test_write_read;
        // Port 1 writes 0xdeadbeef to address 5
        if1.w_req = 2'b10; if1.w_we = 2'b10; if1.w_addr1 = 12'h005; if1.w_wdata1 = 32'hdeadbeef;
        tick();
        n_total++; if (if1.r_gnt !== 2'b10) begin n_bad++; $display("FAIL wr_gnt: got %b want 10", if1.r_gnt); end
        n_total++; if (if1.r_mem_we !== 1'b1) begin n_bad++; $display("FAIL wr_we_c1: got %b want 1", if1.r_mem_we); end
        n_total++; if (if1.r_busy !== 1'b1) begin n_bad++; $display("FAIL wr_busy: got %b want 1", if1.r_busy); end
        n_total++; if (if1.r_mem_addr !== 12'h005) begin n_bad++; $display("FAIL wr_addr: got %h want 005", if1.r_mem_addr); end
        n_total++; if (if1.r_mem_din !== 32'hdeadbeef) begin n_bad++; $display("FAIL wr_din: got %h want deadbeef", if1.r_mem_din); end
        if1.w_req = 2'b00; if1.w_we = 2'b00;
        tick();
        n_total++; if (if1.r_mem_we !== 1'b0) begin n_bad++; $display("FAIL wr_we_c2: got %b want 0", if1.r_mem_we); end
        n_total++; if (if1.r_done !== 2'b00) begin n_bad++; $display("FAIL wr_done_early: got %b want 00", if1.r_done); end
        tick();
        n_total++; if (if1.r_done !== 2'b10) begin n_bad++; $display("FAIL wr_done: got %b want 10", if1.r_done); end
        n_total++; if (if1.r_busy !== 1'b0) begin n_bad++; $display("FAIL wr_busy_end: got %b want 0", if1.r_busy); end
        n_total++; if (mem1[5] !== 32'hdeadbeef) begin n_bad++; $display("FAIL wr_mem: got %h want deadbeef", mem1[5]); end
        $display("txn write p1 addr=005 data=deadbeef");
        // Port 0 reads it back
        if1.w_req = 2'b01; if1.w_we = 2'b00; if1.w_addr0 = 12'h005;
        tick();
        n_total++; if (if1.r_gnt !== 2'b01) begin n_bad++; $display("FAIL rd_gnt: got %b want 01", if1.r_gnt); end
        n_total++; if (if1.r_mem_we !== 1'b0) begin n_bad++; $display("FAIL rd_we: got %b want 0", if1.r_mem_we); end
        if1.w_req = 2'b00;
        tick(); tick();
        n_total++; if (if1.r_done !== 2'b01) begin n_bad++; $display("FAIL rd_done: got %b want 01", if1.r_done); end
        n_total++; if (if1.r_rdata !== 32'hdeadbeef) begin n_bad++; $display("FAIL rd_data: got %h want deadbeef", if1.r_rdata); end
        $display("txn read p0 addr=005 data=%h", if1.r_rdata);
    endtask

    task automatic test_round_robin;
        logic [1:0]  exp_g;
        logic [31:0] exp_d;
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        mem1[1] = 32'h11111111;
        mem1[2] = 32'h22222222;
        if1.w_req = 2'b11; if1.w_we = 2'b00; if1.w_addr0 = 12'h001; if1.w_addr1 = 12'h002;
        for (int i = 0; i < 4; i++) begin
`ifdef MEMARB_FIXPRIO_EN
            exp_g = 2'b01;
`else
            exp_g = (i % 2 == 0) ? 2'b01 : 2'b10;
`endif
            exp_d = (exp_g == 2'b01) ? 32'h11111111 : 32'h22222222;
            tick();
            n_total++; if (if1.r_gnt !== exp_g) begin n_bad++; $display("FAIL rr_gnt[%0d]: got %b want %b", i, if1.r_gnt, exp_g); end
            tick();
            n_total++; if (if1.r_gnt !== 2'b00) begin n_bad++; $display("FAIL rr_gap[%0d]: got %b want 00", i, if1.r_gnt); end
            tick();
            n_total++; if (if1.r_done !== exp_g) begin n_bad++; $display("FAIL rr_done[%0d]: got %b want %b", i, if1.r_done, exp_g); end
            n_total++; if (if1.r_rdata !== exp_d) begin n_bad++; $display("FAIL rr_data[%0d]: got %h want %h", i, if1.r_rdata, exp_d); end
            $display("txn tie access %0d grant=%b data=%h", i, if1.r_done, if1.r_rdata);
        end
        if1.w_req = 2'b00;
        tick();
    endtask

    task automatic test_latency;
        mem3[7] = 32'hcafef00d;
        if3.w_req = 2'b01; if3.w_we = 2'b00; if3.w_addr0 = 12'h007;
        tick();
        n_total++; if (if3.r_gnt !== 2'b01) begin n_bad++; $display("FAIL lat_gnt: got %b want 01", if3.r_gnt); end
        n_total++; if (if3.r_busy !== 1'b1) begin n_bad++; $display("FAIL lat_busy0: got %b want 1", if3.r_busy); end
        if3.w_req = 2'b00;
        for (int i = 1; i <= 3; i++) begin
            tick();
            n_total++; if (if3.r_busy !== 1'b1) begin n_bad++; $display("FAIL lat_busy%0d: got %b want 1", i, if3.r_busy); end
            n_total++; if (if3.r_done !== 2'b00) begin n_bad++; $display("FAIL lat_done_early%0d: got %b want 00", i, if3.r_done); end
        end
        tick();
        n_total++; if (if3.r_done !== 2'b01) begin n_bad++; $display("FAIL lat_done: got %b want 01", if3.r_done); end
        n_total++; if (if3.r_rdata !== 32'hcafef00d) begin n_bad++; $display("FAIL lat_data: got %h want cafef00d", if3.r_rdata); end
        n_total++; if (if3.r_busy !== 1'b0) begin n_bad++; $display("FAIL lat_busy_end: got %b want 0", if3.r_busy); end
        $display("txn lat3 read p0 addr=007 data=%h", if3.r_rdata);
    endtask

    task automatic test_reset_mid;
        mem3[9] = 32'h99999999;
        if3.w_req = 2'b10; if3.w_we = 2'b00; if3.w_addr1 = 12'h009;
        tick();
        n_total++; if (if3.r_gnt !== 2'b10) begin n_bad++; $display("FAIL rmid_gnt: got %b want 10", if3.r_gnt); end
        if3.w_req = 2'b00;
        tick();
        rst_n = 1'b0;
        tick();
        n_total++; if (if3.r_busy !== 1'b0) begin n_bad++; $display("FAIL rmid_busy: got %b want 0", if3.r_busy); end
        n_total++; if (if3.r_gnt !== 2'b00) begin n_bad++; $display("FAIL rmid_gnt0: got %b want 00", if3.r_gnt); end
        n_total++; if (if3.r_rdata !== 32'h0) begin n_bad++; $display("FAIL rmid_rdata: got %h want 0", if3.r_rdata); end
        n_total++; if (if3.r_mem_addr !== 12'h0) begin n_bad++; $display("FAIL rmid_addr: got %h want 0", if3.r_mem_addr); end
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_total++; if (if3.r_done !== 2'b00) begin n_bad++; $display("FAIL rmid_nodone%0d: got %b want 00", i, if3.r_done); end
        end
        // Fresh tie after reset goes to port 0
        if3.w_req = 2'b11; if3.w_addr0 = 12'h007; if3.w_addr1 = 12'h009;
        tick();
        n_total++; if (if3.r_gnt !== 2'b01) begin n_bad++; $display("FAIL rmid_tie: got %b want 01", if3.r_gnt); end
        if3.w_req = 2'b00;
        tick(); tick(); tick(); tick();
        n_total++; if (if3.r_done !== 2'b01) begin n_bad++; $display("FAIL rmid_done: got %b want 01", if3.r_done); end
        n_total++; if (if3.r_rdata !== 32'hcafef00d) begin n_bad++; $display("FAIL rmid_data: got %h want cafef00d", if3.r_rdata); end
        $display("txn reset-mid then tie grant=%b data=%h", if3.r_done, if3.r_rdata);
    endtask

    task automatic test_back_to_back;
        logic [31:0] exp_d [0:2];
        mem1[0] = 32'ha0a0a0a0;
        exp_d[0] = 32'ha0a0a0a0; exp_d[1] = 32'h11111111; exp_d[2] = 32'h22222222;
        if1.w_req = 2'b01; if1.w_we = 2'b00; if1.w_addr0 = 12'h000;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_total++; if (if1.r_gnt !== 2'b01) begin n_bad++; $display("FAIL b2b_gnt[%0d]: got %b want 01", i, if1.r_gnt); end
            n_total++; if (if1.r_mem_we !== 1'b0) begin n_bad++; $display("FAIL b2b_we_a[%0d]: got %b want 0", i, if1.r_mem_we); end
            if1.w_addr0 = 12'(i + 1);
            if (i == 2) if1.w_req = 2'b00;
            tick();
            n_total++; if (if1.r_mem_we !== 1'b0) begin n_bad++; $display("FAIL b2b_we_b[%0d]: got %b want 0", i, if1.r_mem_we); end
            tick();
            n_total++; if (if1.r_done !== 2'b01) begin n_bad++; $display("FAIL b2b_done[%0d]: got %b want 01", i, if1.r_done); end
            n_total++; if (if1.r_rdata !== exp_d[i]) begin n_bad++; $display("FAIL b2b_data[%0d]: got %h want %h", i, if1.r_rdata, exp_d[i]); end
            $display("txn b2b read p0 addr=%0d data=%h", i, if1.r_rdata);
        end
        tick();
        n_total++; if (if1.r_gnt !== 2'b00) begin n_bad++; $display("FAIL b2b_no_extra: got %b want 00", if1.r_gnt); end
    endtask

    initial begin
        rst_n = 1'b0;
        idle_inputs();
        test_reset();
        test_write_read();
        test_round_robin();
        test_latency();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
